// File: rtl/dac_sweep_gen.sv
// dac_sweep_gen
//   Programmable DAC code sweep generator. Each start walks the code between
//   lo and hi (inclusive) in steps of step, in one of four modes:
//     00 single up, 01 single down, 10 triangle (continuous),
//     11 sawtooth (continuous).
//   Every code is offered to the DAC driver with a valid/ready handshake. Once
//   a code is accepted, the generator holds for dwell extra cycles before it
//   computes the next code. stop_i aborts the sweep from any active state.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i            start a sweep (sampled in IDLE only; stop_i wins)
//   stop_i             abort the active sweep
//   mode_i, step_i     sweep mode and code increment (0 is treated as 1)
//   lo_i, hi_i         inclusive code limits (lo > hi flags cfg_err_o)
//   dwell_i            extra hold cycles after each accepted code
//   code_o             current DAC code (holds its last value in IDLE)
//   code_valid_o       code_o is offered; code_ready_i accepts it
//   busy_o             sweep active (any state other than IDLE)
//   dir_o              0 ascending, 1 descending
//   done_o             one-cycle pulse when the sweep ends or is aborted
//   cfg_err_o          pulses with done_o when started with lo > hi
module dac_sweep_gen #(
  parameter int WIDTH   = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH-1:0]   step_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [WIDTH-1:0]   code_o,
  output logic               code_valid_o,
  input  logic               code_ready_i,
  output logic               busy_o,
  output logic               dir_o,
  output logic               done_o,
  output logic               cfg_err_o
);

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_TRI  = 2'b10;
  localparam logic [1:0] M_SAW  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DWELL, S_FINISH} state_t;

  state_t             state;
  logic [1:0]         mode_r;
  logic [WIDTH-1:0]   step_r, lo_r, hi_r;
  logic [DWELL_W-1:0] dwell_r, cnt;

  // Next-code computation from the current code and direction.
  logic [WIDTH:0]     up_sum;
  logic [WIDTH-1:0]   up_next, dn_next, nxt_code;
  logic               nxt_dir, sweep_end;

  always_comb begin
    // One extra bit on the sum so c+step near the top cannot wrap.
    up_sum  = {1'b0, code_o} + {1'b0, step_r};
    up_next = (up_sum > {1'b0, hi_r}) ? hi_r : up_sum[WIDTH-1:0];
    // code_o never drops below lo_r, so the difference cannot underflow.
    dn_next = ((code_o - lo_r) < step_r) ? lo_r : (code_o - step_r);

    nxt_code  = code_o;
    nxt_dir   = dir_o;
    sweep_end = 1'b0;
    if (!dir_o) begin
      if (code_o == hi_r) begin
        case (mode_r)
          M_TRI: begin
            nxt_dir  = 1'b1;
            nxt_code = dn_next;
          end
          M_SAW:   nxt_code  = lo_r;
          default: sweep_end = 1'b1;
        endcase
      end else begin
        nxt_code = up_next;
      end
    end else begin
      if (code_o == lo_r) begin
        case (mode_r)
          M_TRI: begin
            nxt_dir  = 1'b0;
            nxt_code = up_next;
          end
          default: sweep_end = 1'b1;
        endcase
      end else begin
        nxt_code = dn_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mode_r       <= '0;
      step_r       <= '0;
      lo_r         <= '0;
      hi_r         <= '0;
      dwell_r      <= '0;
      cnt          <= '0;
      code_o       <= '0;
      code_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      dir_o        <= 1'b0;
      done_o       <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            mode_r  <= mode_i;
            step_r  <= (step_i == '0) ? WIDTH'(1) : step_i;
            lo_r    <= lo_i;
            hi_r    <= hi_i;
            dwell_r <= dwell_i;
            busy_o  <= 1'b1;
            if (lo_i > hi_i) begin
              // Bad limits: report and finish without emitting anything.
              done_o    <= 1'b1;
              cfg_err_o <= 1'b1;
              state     <= S_FINISH;
            end else begin
              code_o       <= (mode_i == M_DOWN) ? hi_i : lo_i;
              dir_o        <= (mode_i == M_DOWN);
              code_valid_o <= 1'b1;
              state        <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          // Abort wins over a same-cycle handshake.
          if (stop_i) begin
            code_valid_o <= 1'b0;
            done_o       <= 1'b1;
            state        <= S_FINISH;
          end else if (code_ready_i) begin
            code_valid_o <= 1'b0;
            cnt          <= dwell_r;
            state        <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (stop_i) begin
            done_o <= 1'b1;
            state  <= S_FINISH;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (sweep_end) begin
            done_o <= 1'b1;
            state  <= S_FINISH;
          end else begin
            code_o       <= nxt_code;
            dir_o        <= nxt_dir;
            code_valid_o <= 1'b1;
            state        <= S_EMIT;
          end
        end
        S_FINISH: begin
          // done_o was raised on entry; stop_i has nothing left to abort.
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sweep_gen.sv
// Scoreboard bench for dac_sweep_gen. The stimulus process computes each
// sweep's code list from the limits/step/mode with plain arithmetic and
// queues it; a negedge monitor pops and compares on every handshake, and
// also checks handshake stability, valid timing and done/cfg_err pulses.
module tb_dac_sweep_gen;
  localparam int W  = 12;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0, stop_i = 1'b0, code_ready_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [W-1:0]  step_i = '0, lo_i = '0, hi_i = '0;
  logic [DW-1:0] dwell_i = '0;
  logic [W-1:0]  code_o;
  logic          code_valid_o, busy_o, dir_o, done_o, cfg_err_o;

  dac_sweep_gen #(.WIDTH(W), .DWELL_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .step_i(step_i), .lo_i(lo_i), .hi_i(hi_i),
    .dwell_i(dwell_i), .code_o(code_o), .code_valid_o(code_valid_o),
    .code_ready_i(code_ready_i), .busy_o(busy_o), .dir_o(dir_o),
    .done_o(done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [W-1:0] code; logic dir; } exp_t;
  exp_t exp_q[$];
  bit   done_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cnt = 0, done_cnt = 0;
  int   rdy_mode = 0, hold = 0;
  int   up_l[$], dn_l[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Ascending ramp lo..hi and descending ramp hi..lo, clipped at the limits.
  function automatic void ramps(input int lo, input int hi, input int s);
    int c;
    up_l.delete(); dn_l.delete();
    c = lo;
    while (1) begin
      up_l.push_back(c);
      if (c == hi) break;
      c = (c + s > hi) ? hi : c + s;
    end
    c = hi;
    while (1) begin
      dn_l.push_back(c);
      if (c == lo) break;
      c = (c - lo < s) ? lo : c - s;
    end
  endfunction

  function automatic void push_exp(input int c, input bit d);
    exp_t e;
    e.code = W'(c);
    e.dir  = d;
    exp_q.push_back(e);
  endfunction

  // Queues the expected codes; continuous modes are truncated to n codes.
  function automatic void model(input int mode, input int lo, input int hi,
                                input int st, input int n);
    int s, base;
    if (lo > hi) return;
    s = (st == 0) ? 1 : st;
    base = exp_q.size();
    ramps(lo, hi, s);
    case (mode)
      0: foreach (up_l[i]) push_exp(up_l[i], 1'b0);
      1: foreach (dn_l[i]) push_exp(dn_l[i], 1'b1);
      3: while (exp_q.size() < base + n) foreach (up_l[i]) push_exp(up_l[i], 1'b0);
      default: begin
        if (lo == hi) begin
          for (int k = 0; k < n; k++) push_exp(lo, k[0]);
        end else begin
          foreach (up_l[i]) push_exp(up_l[i], 1'b0);
          while (exp_q.size() < base + n) begin
            for (int i = 1; i < dn_l.size(); i++) push_exp(dn_l[i], 1'b1);
            for (int i = 1; i < up_l.size(); i++) push_exp(up_l[i], 1'b0);
          end
        end
      end
    endcase
    if (mode >= 2) while (exp_q.size() > base + n) void'(exp_q.pop_back());
  endfunction

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_stop = 1'b0;
  logic [W-1:0] prev_code = '0;
  int           exp_rise = -1, dwl = 0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_valid = 1'b0; prev_ready = 1'b0; prev_stop = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !prev_stop) begin
        chk("valid held under backpressure", code_valid_o, 1);
        chk("code held under backpressure", code_o, prev_code);
      end
      if (code_valid_o && !prev_valid) chk("valid rise cycle", cyc, exp_rise);
      if (code_valid_o) chk("busy with valid", busy_o, 1);
      if (code_valid_o && code_ready_i && !stop_i) begin
        if (exp_q.size() == 0) chk("unexpected extra code", exp_q.size(), 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("code", code_o, e.code);
          chk("dir", dir_o, e.dir);
        end
        acc_cnt++;
        exp_rise = cyc + dwl + 2;
      end
      if (done_o) begin
        done_cnt++;
        chk("valid low at done", code_valid_o, 0);
        if (done_q.size() == 0) chk("unexpected done", done_q.size(), 1);
        else chk("cfg_err with done", cfg_err_o, done_q.pop_front());
      end else if (cfg_err_o) begin
        chk("cfg_err without done", done_o, 1);
      end
      if (start_i && !stop_i && !busy_o) begin
        dwl = dwell_i;
        exp_rise = cyc + 1;
      end
      prev_valid = code_valid_o; prev_ready = code_ready_i;
      prev_stop = stop_i; prev_code = code_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_cycle();
    @(posedge clk_i); #1;
    if (hold > 0) begin
      code_ready_i = 1'b0;
      hold--;
    end else begin
      case (rdy_mode)
        0:       code_ready_i = 1'b1;
        1:       code_ready_i = ($urandom_range(0, 3) != 0);
        default: code_ready_i = 1'b0;
      endcase
    end
  endtask

  // n > 0: abort with stop_i after n accepted codes (required for continuous).
  task automatic run(input int mode, input int lo, input int hi, input int st,
                     input int dw, input int n, input int rm, input int hd);
    int  base_acc, base_done, budget, last;
    bit  cont, has_last;
    cont = (mode >= 2) && (lo <= hi);
    model(mode, lo, hi, st, n);
    has_last = (exp_q.size() > 0) && (n == 0);
    last = has_last ? int'(exp_q[exp_q.size()-1].code) : 0;
    if (n == 0) done_q.push_back(lo > hi);
    rdy_mode = rm; hold = hd;
    base_acc = acc_cnt; base_done = done_cnt;
    mode_i = 2'(mode); lo_i = W'(lo); hi_i = W'(hi); step_i = W'(st); dwell_i = DW'(dw);
    start_i = 1'b1;
    step_cycle();
    // Second start while busy must be ignored; scrambled inputs must not leak in.
    mode_i = 2'($urandom); lo_i = W'($urandom); hi_i = W'($urandom);
    step_i = W'($urandom); dwell_i = DW'($urandom);
    step_cycle();
    start_i = 1'b0;
    if (n > 0) begin
      budget = 4000;
      while ((acc_cnt - base_acc) < n && budget > 0) begin step_cycle(); budget--; end
      chk("codes accepted before stop", acc_cnt - base_acc, n);
      stop_i = 1'b1;
      done_q.push_back(1'b0);
      step_cycle();
      stop_i = 1'b0;
    end
    budget = 4000;
    while (done_cnt == base_done && budget > 0) begin step_cycle(); budget--; end
    chk("done pulses", done_cnt - base_done, 1);
    @(negedge clk_i);
    chk("busy low after done", busy_o, 0);
    if (n > 0 && !cont) exp_q.delete();
    chk("codes left unemitted", exp_q.size(), 0);
    if (has_last) chk("code held in idle", code_o, last);
    exp_q.delete(); done_q.delete();
    rdy_mode = 0;
    step_cycle();
  endtask

  initial begin
    int mode, lo, hi, st, dw, n, t, rng, eff;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset code_o", code_o, 0);
    chk("reset code_valid_o", code_valid_o, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset dir_o", dir_o, 0);
    chk("reset done_o", done_o, 0);
    chk("reset cfg_err_o", cfg_err_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    step_cycle();

    run(0, 0, 4095, 819, 0, 0, 0, 0);   // full-scale ramp
    run(0, 0, 1000, 300, 0, 0, 0, 0);   // clip at hi
    run(1, 0, 1000, 300, 0, 0, 0, 0);   // single down
    run(2, 100, 400, 150, 0, 9, 0, 0);  // triangle
    run(3, 100, 400, 150, 0, 7, 0, 0);  // sawtooth
    run(0, 0, 20, 7, 3, 0, 0, 5);       // backpressure + dwell
    run(0, 0, 4000, 100, 6, 1, 0, 0);   // stop during dwell
    run(0, 500, 200, 5, 0, 0, 0, 0);    // lo > hi
    run(0, 0, 3, 0, 0, 0, 1, 0);        // step 0 acts as 1
    run(0, 4000, 4095, 4095, 0, 0, 0, 0); // no wrap at top
    run(1, 5, 4095, 4095, 0, 0, 0, 0);  // no underflow at bottom
    run(0, 7, 7, 3, 1, 0, 1, 0);        // lo == hi, single
    run(1, 7, 7, 3, 1, 0, 1, 0);
    run(2, 7, 7, 0, 0, 6, 1, 0);        // lo == hi, continuous
    run(3, 7, 7, 2, 1, 5, 1, 0);

    // start and stop together in IDLE: nothing starts
    start_i = 1'b1; stop_i = 1'b1;
    step_cycle();
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk_i);
    chk("start+stop busy", busy_o, 0);
    chk("start+stop valid", code_valid_o, 0);
    step_cycle();

    // asynchronous reset while a code is offered
    rdy_mode = 2;
    mode_i = 2'b00; lo_i = 12'd0; hi_i = 12'd100; step_i = 12'd10; dwell_i = '0;
    start_i = 1'b1;
    step_cycle();
    start_i = 1'b0;
    step_cycle(); step_cycle();
    chk("valid before reset", code_valid_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("mid-sweep reset code_o", code_o, 0);
    chk("mid-sweep reset code_valid_o", code_valid_o, 0);
    chk("mid-sweep reset busy_o", busy_o, 0);
    chk("mid-sweep reset dir_o", dir_o, 0);
    chk("mid-sweep reset done_o", done_o, 0);
    chk("mid-sweep reset cfg_err_o", cfg_err_o, 0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    exp_q.delete(); done_q.delete();
    rdy_mode = 0;
    step_cycle();
    @(negedge clk_i);
    chk("idle after reset", busy_o, 0);
    step_cycle();

    // randomized sweeps
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 3);
      lo = $urandom_range(0, 4095);
      hi = $urandom_range(0, 4095);
      if (lo > hi && $urandom_range(0, 7) != 0) begin t = lo; lo = hi; hi = t; end
      st = $urandom_range(0, 4095);
      if (lo <= hi) begin
        rng = hi - lo;
        eff = (st == 0) ? 1 : st;
        if (rng / eff > 40) st = rng / 40 + 1;
      end
      dw = $urandom_range(0, 4);
      n = (mode >= 2 && lo <= hi) ? $urandom_range(3, 20) : 0;
      run(mode, lo, hi, st, dw, n, $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
